// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external 32-bit combinational ALU: decodes MIPS-style
// commands, drives the ALU from registers, and returns a registered response.
// Optional SLT support is enabled by defining ALU_ISSUE_SLT_EN.
module alu_issue_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_aluop,
  input  logic [5:0]       req_funct,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_binvert,
  output logic             alu_carryin,
  output logic [1:0]       alu_operation,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic             rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  typedef enum logic [1:0] {K_ARITH, K_LOGIC, K_SLT, K_ILL} kind_t;

  state_t state;
  kind_t  kind;
  kind_t  d_kind;
  logic       d_binvert;
  logic       d_carryin;
  logic [1:0] d_op;

  always_comb begin
    d_kind    = K_ILL;
    d_binvert = 1'b0;
    d_carryin = 1'b0;
    d_op      = 2'b00;
    case (req_aluop)
      2'b00: begin
        d_kind = K_ARITH;
        d_op   = 2'b10;
      end
      2'b01: begin
        d_kind    = K_ARITH;
        d_op      = 2'b10;
        d_binvert = 1'b1;
        d_carryin = 1'b1;
      end
      2'b10: begin
        case (req_funct)
          6'b100000: begin
            d_kind = K_ARITH;
            d_op   = 2'b10;
          end
          6'b100010: begin
            d_kind    = K_ARITH;
            d_op      = 2'b10;
            d_binvert = 1'b1;
            d_carryin = 1'b1;
          end
          6'b100100: d_kind = K_LOGIC;
          6'b100101: begin
            d_kind = K_LOGIC;
            d_op   = 2'b01;
          end
`ifdef ALU_ISSUE_SLT_EN
          6'b101010: begin
            d_kind    = K_SLT;
            d_op      = 2'b10;
            d_binvert = 1'b1;
            d_carryin = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  logic             ovf_c;
  logic             slt_bit;
  logic [WIDTH-1:0] n_result;
  logic             n_carry;
  logic             n_zero;
  logic             n_ovf;
  logic             n_err;

  // Overflow uses the registered operands, i.e. exactly what the ALU saw.
  always_comb begin
    ovf_c    = (alu_a[WIDTH-1] == (alu_b[WIDTH-1] ^ alu_binvert)) &&
               (alu_result[WIDTH-1] != alu_a[WIDTH-1]);
    slt_bit  = alu_result[WIDTH-1] ^ ovf_c;
    n_result = '0;
    n_carry  = 1'b0;
    n_zero   = 1'b0;
    n_ovf    = 1'b0;
    n_err    = 1'b0;
    case (kind)
      K_ARITH: begin
        n_result = alu_result;
        n_carry  = alu_carryout;
        n_zero   = alu_zero;
        n_ovf    = ovf_c;
      end
      K_LOGIC: begin
        n_result = alu_result;
        n_zero   = alu_zero;
      end
      K_SLT: begin
        n_result = {{(WIDTH-1){1'b0}}, slt_bit};
        n_zero   = ~slt_bit;
      end
      K_ILL: n_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      kind          <= K_ILL;
      req_ready     <= 1'b1;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_binvert   <= 1'b0;
      alu_carryin   <= 1'b0;
      alu_operation <= 2'b00;
      rsp_valid     <= 1'b0;
      rsp_result    <= '0;
      rsp_carry     <= 1'b0;
      rsp_zero      <= 1'b0;
      rsp_ovf       <= 1'b0;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            kind          <= d_kind;
            alu_a         <= (d_kind == K_ILL) ? '0 : req_a;
            alu_b         <= (d_kind == K_ILL) ? '0 : req_b;
            alu_binvert   <= d_binvert;
            alu_carryin   <= d_carryin;
            alu_operation <= d_op;
            req_ready     <= 1'b0;
            state         <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= n_result;
          rsp_carry  <= n_carry;
          rsp_zero   <= n_zero;
          rsp_ovf    <= n_ovf;
          rsp_err    <= n_err;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU attached; directed
// commands push expected responses, a monitor pops them on each response handshake.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_aluop;
  logic [5:0]  req_funct;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_binvert;
  logic        alu_carryin;
  logic [1:0]  alu_operation;
  logic [31:0] alu_result;
  logic        alu_carryout;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_zero;
  logic        rsp_ovf;
  logic        rsp_err;

  alu_issue_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_aluop(req_aluop),
    .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_binvert(alu_binvert),
    .alu_carryin(alu_carryin), .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_carryout(alu_carryout), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
  );

  // Behavioural ALU; the adder carry is produced for every operation.
  logic [31:0] bb;
  logic [32:0] sum;
  always_comb begin
    bb  = alu_b ^ {32{alu_binvert}};
    sum = {1'b0, alu_a} + {1'b0, bb} + {32'd0, alu_carryin};
    case (alu_operation)
      2'b00:   alu_result = alu_a & bb;
      2'b01:   alu_result = alu_a | bb;
      2'b10:   alu_result = sum[31:0];
      default: alu_result = '0;
    endcase
    alu_carryout = sum[32];
    alu_zero     = (alu_result == 32'd0);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic [31:0] result;
    logic        carry;
    logic        zero;
    logic        ovf;
    logic        err;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_accept = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor samples 2 time units after the falling edge, clear of both edges.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    #2;
    if (rsp_valid && !prev_valid)
      chk("latency", cyc - last_accept, 32'd2);
    prev_valid = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, ".result"}, rsp_result, e.result);
        chk({e.name, ".carry"}, {31'd0, rsp_carry}, {31'd0, e.carry});
        chk({e.name, ".zero"}, {31'd0, rsp_zero}, {31'd0, e.zero});
        chk({e.name, ".ovf"}, {31'd0, rsp_ovf}, {31'd0, e.ovf});
        chk({e.name, ".err"}, {31'd0, rsp_err}, {31'd0, e.err});
      end
    end
  end

  // Called at a falling edge; returns at the falling edge of the EXEC cycle.
  task automatic issue(input string nm, input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input bit push,
                       input logic [31:0] er, input logic ec, input logic ez,
                       input logic eo, input logic ee);
    exp_t e;
    int t;
    if (push) begin
      e.name = nm; e.result = er; e.carry = ec; e.zero = ez; e.ovf = eo; e.err = ee;
      q.push_back(e);
    end
    req_aluop = op; req_funct = fn; req_a = a; req_b = b; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) chk({nm, ".accept_timeout"}, 32'd1, 32'd0);
    last_accept = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    int t;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_aluop = 2'b00; req_funct = 6'd0; req_a = '0; req_b = '0;
    repeat (3) @(negedge clk);
    chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst.rsp_result", rsp_result, 32'd0);
    chk("rst.alu_a", alu_a, 32'd0);
    chk("rst.alu_op", {30'd0, alu_operation}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue("and", 2'b10, 6'b100100, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 32'h00000000, 0, 1, 0, 0);
    issue("or",  2'b10, 6'b100101, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 32'hFFFFFFFF, 0, 0, 0, 0);
    issue("add", 2'b00, 6'b000000, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 32'hFFFFFFFF, 0, 0, 0, 0);
    issue("sub", 2'b01, 6'b000000, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 32'h4B4B4B4B, 1, 0, 1, 0);
    issue("and_mask", 2'b10, 6'b100100, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0, 0, 0, 0);
    issue("radd", 2'b10, 6'b100000, 32'd3, 32'd4, 1, 32'd7, 0, 0, 0, 0);
    issue("rsub", 2'b10, 6'b100010, 32'd5, 32'd5, 1, 32'd0, 1, 1, 0, 0);
    issue("ill_funct", 2'b10, 6'b000111, 32'h00001234, 32'd5, 1, 32'd0, 0, 0, 0, 1);
    chk("ill.alu_a", alu_a, 32'd0);
    chk("ill.alu_b", alu_b, 32'd0);
    chk("ill.alu_op", {30'd0, alu_operation}, 32'd0);
    issue("ill_op11", 2'b11, 6'b100000, 32'd9, 32'd9, 1, 32'd0, 0, 0, 0, 1);
`ifdef ALU_ISSUE_SLT_EN
    issue("slt", 2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 1, 32'd1, 0, 0, 0, 0);
`else
    issue("slt_ill", 2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 1, 32'd0, 0, 0, 0, 1);
`endif

    // Backpressure: response held for 5 cycles with a second request pending.
    while (!req_ready) @(negedge clk);
    rsp_ready = 1'b0;
    issue("ovf_add", 2'b00, 6'd0, 32'h7FFFFFFF, 32'd1, 1, 32'h80000000, 0, 0, 1, 0);
    @(negedge clk);
    begin
      exp_t e;
      e.name = "pend_add"; e.result = 32'd2; e.carry = 0; e.zero = 0; e.ovf = 0; e.err = 0;
      q.push_back(e);
    end
    req_aluop = 2'b00; req_a = 32'd1; req_b = 32'd1; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall.rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall.req_ready", {31'd0, req_ready}, 32'd0);
      chk("stall.rsp_result", rsp_result, 32'h80000000);
      chk("stall.rsp_ovf", {31'd0, rsp_ovf}, 32'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    chk("hs.req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("post_hs.req_ready", {31'd0, req_ready}, 32'd1);
    chk("post_hs.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    last_accept = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pend.accepted", {31'd0, req_ready}, 32'd0);

    // Reset during EXEC discards the command.
    while (!req_ready) @(negedge clk);
    issue("rst_cmd", 2'b00, 6'd0, 32'd10, 32'd20, 0, 32'd0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("midrst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("midrst.req_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
    end
    issue("add_after_rst", 2'b00, 6'd0, 32'd3, 32'd4, 1, 32'd7, 0, 0, 0, 0);

    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain.pending", q.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
